// File: rtl/ex_alu_unit_if.sv
// Operand and result channels of the execute-stage ALU.
// A transfer happens on the rising edge where valid and ready are both high.
// Once valid is raised, it and its payload stay unchanged until that edge.
interface ex_alu_unit_if #(
  parameter int XLEN   = 32,
  parameter int ALU_SI = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [ALU_SI-1:0] alu_func;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [4:0]        rd_in;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   result;
  logic              zero;
  logic [4:0]        rd_out;

  modport master (
    output in_valid, alu_func, op_a, op_b, rd_in, out_ready,
    input  in_ready, out_valid, result, zero, rd_out
  );

  modport slave (
    input  in_valid, alu_func, op_a, op_b, rd_in, out_ready,
    output in_ready, out_valid, result, zero, rd_out
  );
endinterface

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU with a registered result slot.
// Non-zero shifts optionally run on a 1-bit-per-cycle serial shifter.
module ex_alu_unit #(
  parameter int XLEN         = 32,
  parameter int ALU_SI       = 4,
  parameter int SERIAL_SHIFT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  ex_alu_unit_if.slave alu,
  output logic         busy
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [ALU_SI-1:0] F_ADD  = ALU_SI'(0);
  localparam logic [ALU_SI-1:0] F_SLL  = ALU_SI'(1);
  localparam logic [ALU_SI-1:0] F_SLT  = ALU_SI'(2);
  localparam logic [ALU_SI-1:0] F_SLTU = ALU_SI'(3);
  localparam logic [ALU_SI-1:0] F_XOR  = ALU_SI'(4);
  localparam logic [ALU_SI-1:0] F_SRL  = ALU_SI'(5);
  localparam logic [ALU_SI-1:0] F_OR   = ALU_SI'(6);
  localparam logic [ALU_SI-1:0] F_AND  = ALU_SI'(7);
  localparam logic [ALU_SI-1:0] F_SUB  = ALU_SI'(8);
  localparam logic [ALU_SI-1:0] F_SEQ  = ALU_SI'(9);
  localparam logic [ALU_SI-1:0] F_SRA  = ALU_SI'(13);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e            state_q;
  logic [XLEN-1:0]   acc_q;
  logic [SHW-1:0]    cnt_q;
  logic [ALU_SI-1:0] func_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   result_q;
  logic              zero_q;
  logic [4:0]        rd_out_q;
  logic              out_valid_q;

  logic [SHW-1:0]    shamt;
  logic              is_shift;
  logic              accept;
  logic              serial_start;
  logic [XLEN-1:0]   comb_res;
  logic [XLEN-1:0]   step;

  assign shamt        = alu.op_b[SHW-1:0];
  assign is_shift     = (alu.alu_func == F_SLL) || (alu.alu_func == F_SRL) ||
                        (alu.alu_func == F_SRA);
  assign alu.in_ready = (state_q == IDLE) && !flush && (!out_valid_q || alu.out_ready);
  assign accept       = alu.in_valid && alu.in_ready;
  assign serial_start = (SERIAL_SHIFT != 0) && is_shift && (shamt != '0);

  always_comb begin
    comb_res = '0;
    case (alu.alu_func)
      F_ADD:   comb_res = alu.op_a + alu.op_b;
      F_SUB:   comb_res = alu.op_a - alu.op_b;
      F_SLL:   comb_res = alu.op_a << shamt;
      F_SLT:   comb_res = {{(XLEN-1){1'b0}}, ($signed(alu.op_a) < $signed(alu.op_b))};
      F_SLTU:  comb_res = {{(XLEN-1){1'b0}}, (alu.op_a < alu.op_b)};
      F_XOR:   comb_res = alu.op_a ^ alu.op_b;
      F_SRL:   comb_res = alu.op_a >> shamt;
      F_SRA:   comb_res = $unsigned($signed(alu.op_a) >>> shamt);
      F_OR:    comb_res = alu.op_a | alu.op_b;
      F_AND:   comb_res = alu.op_a & alu.op_b;
      F_SEQ:   comb_res = {{(XLEN-1){1'b0}}, (alu.op_a == alu.op_b)};
      default: comb_res = '0;
    endcase
  end

  // One bit of the latched shift; SRL is the fallback since only shifts reach SHIFT.
  always_comb begin
    step = acc_q >> 1;
    if (func_q == F_SLL) begin
      step = acc_q << 1;
    end else if (func_q == F_SRA) begin
      step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      func_q      <= '0;
      rd_q        <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      rd_out_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (out_valid_q && alu.out_ready) begin
            out_valid_q <= 1'b0;
          end
          if (accept) begin
            if (serial_start) begin
              acc_q   <= alu.op_a;
              cnt_q   <= shamt;
              func_q  <= alu.alu_func;
              rd_q    <= alu.rd_in;
              state_q <= SHIFT;
            end else begin
              result_q    <= comb_res;
              zero_q      <= (comb_res == '0);
              rd_out_q    <= alu.rd_in;
              out_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc_q <= step;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            result_q    <= step;
            zero_q      <= (step == '0);
            rd_out_q    <= rd_q;
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = (state_q == SHIFT);
  assign alu.out_valid = out_valid_q;
  assign alu.result    = result_q;
  assign alu.zero      = zero_q;
  assign alu.rd_out    = rd_out_q;
endmodule

// File: tb/tb_ex_alu_unit.sv
// Bench for ex_alu_unit: serial-shift instance behind a scoreboard plus a
// barrel-shift instance checked for single-cycle completion.
module tb_ex_alu_unit;
  localparam time CLK = 10ns;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic flush2 = 1'b0;
  logic busy, busy2;

  ex_alu_unit_if #(.XLEN(32), .ALU_SI(4)) m ();
  ex_alu_unit_if #(.XLEN(32), .ALU_SI(4)) m2 ();

  ex_alu_unit #(.XLEN(32), .ALU_SI(4), .SERIAL_SHIFT(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .alu(m.slave), .busy(busy)
  );
  ex_alu_unit #(.XLEN(32), .ALU_SI(4), .SERIAL_SHIFT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .alu(m2.slave), .busy(busy2)
  );

  // ---------------- clock / reset ----------------
  always #(CLK/2) clk = ~clk;

  initial begin
    #(CLK * 90000);
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_err = 0;
  logic [37:0] exp_q[$];  // {result, zero, rd}
  bit rand_ready = 1'b0;
  bit ready_force = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    int s;
    logic [31:0] r;
    s = int'(b[4:0]);
    r = '0;
    case (f)
      4'd0:  r = a + b;
      4'd8:  r = a - b;
      4'd2:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  r = (a < b) ? 32'd1 : 32'd0;
      4'd4:  r = a ^ b;
      4'd6:  r = a | b;
      4'd7:  r = a & b;
      4'd9:  r = (a == b) ? 32'd1 : 32'd0;
      4'd1:  for (int i = 0; i < 32; i++) r[i] = (i >= s) ? a[i-s] : 1'b0;
      4'd5:  for (int i = 0; i < 32; i++) r[i] = (i + s < 32) ? a[i+s] : 1'b0;
      4'd13: for (int i = 0; i < 32; i++) r[i] = (i + s < 32) ? a[i+s] : a[31];
      default: r = '0;
    endcase
    return r;
  endfunction

  // ---------------- output-ready driver ----------------
  always @(posedge clk) begin
    #1;
    m.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    int n;
    logic [31:0] r;
    n = 0;
    @(negedge clk);
    m.in_valid = 1'b1; m.alu_func = f; m.op_a = a; m.op_b = b; m.rd_in = rd;
    #1;
    while (!m.in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept_timeout", {31'd0, m.in_ready}, 32'd1);
    if (m.in_ready) begin
      r = ref_alu(f, a, b);
      exp_q.push_back({r, (r == 32'd0), rd});
      @(posedge clk);
      #1;
    end
    m.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_ready = 1'b0;
    ready_force = 1'b1;
    @(negedge clk);
    while ((exp_q.size() != 0 || m.out_valid || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'd0, (n < 500)}, 32'd1);
  endtask

  task automatic op2(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = ref_alu(f, a, b);
    @(negedge clk);
    m2.in_valid = 1'b1; m2.alu_func = f; m2.op_a = a; m2.op_b = b; m2.rd_in = 5'd7;
    #1;
    chk("bs_in_ready", {31'd0, m2.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    m2.in_valid = 1'b0;
    @(negedge clk);
    chk("bs_out_valid", {31'd0, m2.out_valid}, 32'd1);
    chk("bs_busy", {31'd0, busy2}, 32'd0);
    chk("bs_result", m2.result, r);
    chk("bs_zero", {31'd0, m2.zero}, {31'd0, (r == 32'd0)});
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        prev_hold = 1'b0;
  logic [31:0] prev_res;
  logic [4:0]  prev_rd;

  always @(negedge clk) begin
    logic [37:0] e;
    if (rst_n && prev_hold) begin
      chk("hold_valid", {31'd0, m.out_valid}, 32'd1);
      chk("hold_result", m.result, prev_res);
      chk("hold_rd", {27'd0, m.rd_out}, {27'd0, prev_rd});
    end
    if (rst_n && m.out_valid && m.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_output: got result %h with no pending operation", m.result);
      end else begin
        e = exp_q.pop_front();
        chk("result", m.result, e[37:6]);
        chk("zero", {31'd0, m.zero}, {31'd0, e[5]});
        chk("rd_out", {27'd0, m.rd_out}, {27'd0, e[4:0]});
      end
    end
    prev_hold = rst_n && !flush && m.out_valid && !m.out_ready;
    prev_res  = m.result;
    prev_rd   = m.rd_out;
  end

  // ---------------- stimulus ----------------
  logic [3:0] f;
  logic [31:0] a, b;
  bit seen;

  initial begin
    m.in_valid = 1'b0; m.alu_func = '0; m.op_a = '0; m.op_b = '0; m.rd_in = '0;
    m.out_ready = 1'b1;
    m2.in_valid = 1'b0; m2.alu_func = '0; m2.op_a = '0; m2.op_b = '0; m2.rd_in = '0;
    m2.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, m.out_valid}, 32'd0);
    chk("rst_result", m.result, 32'd0);
    chk("rst_zero", {31'd0, m.zero}, 32'd0);
    chk("rst_rd_out", {27'd0, m.rd_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // wrap-around add, one-cycle latency
    send(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd1);
    @(negedge clk);
    chk("add_latency", {31'd0, m.out_valid}, 32'd1);
    send(4'd2, 32'hFFFF_FFFF, 32'd1, 5'd2);
    send(4'd3, 32'hFFFF_FFFF, 32'd1, 5'd3);
    send(4'd9, 32'd7, 32'd7, 5'd4);
    drain();

    // serial SRA by 4
    send(4'd13, 32'h8000_0000, 32'd4, 5'd5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sra_busy", {31'd0, busy}, 32'd1);
      chk("sra_in_ready", {31'd0, m.in_ready}, 32'd0);
      chk("sra_no_out", {31'd0, m.out_valid}, 32'd0);
    end
    @(negedge clk);
    chk("sra_out_valid", {31'd0, m.out_valid}, 32'd1);
    chk("sra_result", m.result, 32'hF800_0000);
    send(4'd1, 32'h1234_5678, 32'd0, 5'd6);
    @(negedge clk);
    chk("sll0_latency", {31'd0, m.out_valid}, 32'd1);
    drain();

    // back-pressure, then drain and accept on the same edge
    ready_force = 1'b0;
    @(negedge clk);
    send(4'd0, 32'd2, 32'd3, 5'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, m.out_valid}, 32'd1);
      chk("bp_result", m.result, 32'd5);
      chk("bp_in_ready", {31'd0, m.in_ready}, 32'd0);
    end
    ready_force = 1'b1;
    send(4'd0, 32'd10, 32'd20, 5'd8);
    @(negedge clk);
    chk("swap_valid", {31'd0, m.out_valid}, 32'd1);
    chk("swap_result", m.result, 32'd30);
    drain();

    // flush in IDLE blocks the accept
    @(negedge clk);
    flush = 1'b1;
    m.in_valid = 1'b1; m.alu_func = 4'd0; m.op_a = 32'd1; m.op_b = 32'd1; m.rd_in = 5'd9;
    #1;
    chk("flush_in_ready", {31'd0, m.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    m.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_no_accept", {31'd0, m.out_valid}, 32'd0);

    // flush on the third SHIFT cycle kills the shift
    send(4'd5, 32'h0000_00F0, 32'd31, 5'd10);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m.out_valid) seen = 1'b1;
    end
    chk("flush_no_output", {31'd0, seen}, 32'd0);
    send(4'd0, 32'd100, 32'd23, 5'd11);
    drain();

    // reset in the middle of a shift
    send(4'd1, 32'd1, 32'd20, 5'd12);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_valid", {31'd0, m.out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_result", m.result, 32'd0);
    chk("mid_rst_rd", {27'd0, m.rd_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(4'd4, 32'hFF, 32'h0F, 5'd13);
    @(negedge clk);
    chk("xor_latency", {31'd0, m.out_valid}, 32'd1);
    chk("xor_result", m.result, 32'hF0);
    drain();

    // randomized traffic with random back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      f = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 1) == 0) b[4:0] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) b = a;
      send(f, a, b, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    // barrel-shift instance: every op in one cycle
    op2(4'd13, 32'h8000_0000, 32'd31);
    op2(4'd1, 32'h0000_0001, 32'd31);
    for (int i = 0; i < 30; i++) begin
      op2(4'($urandom_range(0, 15)), $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
